slt_serial_compare: RTL and testbench
=====================================

// Module: slt_serial_compare
// PURPOSE
//  Multi-cycle set-less-than comparator for the 32-bit MIPS R-type datapath (slt/sltu).
//  Subtracts b from a, BITS_PER_CYCLE bits per clock, LSB first, and tracks the borrow.
//  Produces the 1-bit less-than flag. The 32-bit zero-extending buffer consumes this flag
//  and widens it into the ALU result word.
// PARAMETERS
//  WIDTH           32  operand width in bits
//  BITS_PER_CYCLE  1   bits processed per RUN cycle; must divide WIDTH (1,2,4,8,16,32)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE and DONE
//  is_signed  in   1      1 = slt (two's complement), 0 = sltu (unsigned)
//  a          in   WIDTH  operand rs; captured on the accepted start cycle
//  b          in   WIDTH  operand rt; captured on the accepted start cycle
//  busy       out  1      high while in RUN
//  done       out  1      one-cycle pulse when lt becomes valid
//  lt         out  1      1 if a < b in the selected mode; feeds the zero-extend buffer
// BEHAVIOUR
//  - Reset (rst_n low, any time, including mid-RUN): go to IDLE at once.
//    busy=0, done=0, lt=0. Clear the operand shift registers, borrow, bit counter and mode.
//  - States and transitions:
//    IDLE: start=1 -> capture a, b, is_signed; borrow=0; count=0; go to RUN.
//    RUN: each cycle process the next BITS_PER_CYCLE bits of a-b with ripple borrow.
//      count += BITS_PER_CYCLE. After WIDTH/BITS_PER_CYCLE cycles, go to DONE.
//    DONE: done=1 for exactly this cycle, lt updated. Next cycle: start=1 -> RUN with a
//      fresh capture (back-to-back); otherwise -> IDLE.
//  - Latency: start accepted at edge N -> done high in cycle N+WIDTH/BITS_PER_CYCLE+1.
//    For the defaults that is 33 cycles.
//  - start during RUN is ignored; the in-flight operation is not disturbed.
//  - Changes on a/b/is_signed after capture have no effect.
//  - Result rules. Let d = MSB of (a-b) and br = final borrow-out.
//    Unsigned: lt = br.
//    Signed: ovf = (a[MSB]^b[MSB]) & (a[MSB]^d); lt = d ^ ovf.
//  - a == b gives lt=0 in both modes.
//  - lt holds its value through IDLE until the next DONE overwrites it.
//  - busy and done are never high together.
// CONFIGURATION
//  Macro SLT_EQ_FLAG_EN:
//  - Defined: adds output port eq (1 bit). eq = 1 when all WIDTH difference bits are zero.
//    Tracked as a sticky OR of the difference bits during RUN. eq is updated in DONE
//    together with lt and reset to 0.
//  - Undefined: no eq port and no zero-tracking logic. All other behaviour is unchanged.
// TESTING
//  1. Reset mid-op: rst_n low 2 cycles after start -> busy=0, done=0, lt=0 immediately;
//     a new start then completes normally.
//  2. Signed/unsigned split: a=32'hFFFF_FFFF, b=32'h0000_0001.
//     is_signed=1 -> lt=1. is_signed=0 -> lt=0. done 33 cycles after start.
//  3. Overflow: a=32'h8000_0000, b=32'h7FFF_FFFF, is_signed=1 -> lt=1.
//     a=32'h7FFF_FFFF, b=32'h8000_0000, is_signed=1 -> lt=0.
//  4. Equality: a=b=32'h1234_5678, both modes -> lt=0. With SLT_EQ_FLAG_EN, eq=1.
//     a=5, b=6 -> eq=0, lt=1.
//  5. Handshake: start held high through RUN with changing a/b -> exactly one done per
//     accepted start; the result matches the captured operands.
//     start high in DONE -> the next op starts with no idle cycle.
//  6. Sweep BITS_PER_CYCLE in {1,4,32}: 1000 random a/b/is_signed versus a $signed /
//     unsigned reference model. Latency = 32/BITS_PER_CYCLE+1.

Source files
------------

// File: rtl/slt_serial_compare.sv
// -----------------------------------------------------------------------------
// slt_serial_compare
//   Multi-cycle set-less-than comparator for the slt/sltu R-type datapath.
//   Computes a - b, BITS_PER_CYCLE bits per clock from the LSB upwards,
//   carrying a ripple borrow between cycles. It then derives the 1-bit
//   less-than flag, which a downstream zero-extend buffer widens into the
//   ALU result word.
//
//   Optional feature macro: SLT_EQ_FLAG_EN
//     defined   -> extra output eq_o (all difference bits zero)
//     undefined -> no eq_o port and no zero-tracking logic
//
// Parameters
//   WIDTH           operand width in bits
//   BITS_PER_CYCLE  bits processed per RUN cycle; must divide WIDTH
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start_i      in   request, sampled only in IDLE and DONE
//   is_signed_i  in   1 = slt (two's complement), 0 = sltu (unsigned)
//   a_i          in   operand rs, captured on the accepted start cycle
//   b_i          in   operand rt, captured on the accepted start cycle
//   busy_o       out  high while in RUN
//   done_o       out  one-cycle pulse when lt_o becomes valid
//   lt_o         out  1 if a < b in the selected mode; held until next DONE
//   eq_o         out  (SLT_EQ_FLAG_EN only) 1 if a == b; updated with lt_o
// -----------------------------------------------------------------------------
module slt_serial_compare #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lt_o
`ifdef SLT_EQ_FLAG_EN
  ,
  output logic             eq_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] STEP = CW'(BITS_PER_CYCLE);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Full-subtractor borrow-out for one bit of a - b.
  function automatic logic borrow_bit(input logic ai, input logic bi, input logic bin);
    return (~ai & bi) | (~(ai ^ bi) & bin);
  endfunction

  // Full-subtractor difference for one bit of a - b.
  function automatic logic diff_bit(input logic ai, input logic bi, input logic bin);
    return ai ^ bi ^ bin;
  endfunction

  state_e                    state_q;
  logic [WIDTH-1:0]          a_q;
  logic [WIDTH-1:0]          b_q;
  logic                      borrow_q;
  logic [CW-1:0]             count_q;
  logic                      signed_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      lt_q;

  logic [BITS_PER_CYCLE-1:0] diff_d;
  logic                      borrow_d;
  logic [CW-1:0]             count_d;
  logic                      last_d;
  logic                      lt_d;
  logic                      br_s;
  logic                      a_msb_s;
  logic                      b_msb_s;
  logic                      d_msb_s;
  logic                      ovf_s;

`ifdef SLT_EQ_FLAG_EN
  logic                      nz_q;
  logic                      nz_d;
  logic                      eq_q;
`endif

  // Slice datapath: ripple-borrow subtract of the low BITS_PER_CYCLE operand bits
  // and the less-than flag as it would read if this were the final slice.
  always_comb begin
    br_s   = borrow_q;
    diff_d = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      diff_d[i] = diff_bit(a_q[i], b_q[i], br_s);
      br_s      = borrow_bit(a_q[i], b_q[i], br_s);
    end
    borrow_d = br_s;
    count_d  = count_q + STEP;
    last_d   = (count_d == LAST);

    // On the final slice the top bit of the shifted operands is the original MSB.
    a_msb_s  = a_q[BITS_PER_CYCLE-1];
    b_msb_s  = b_q[BITS_PER_CYCLE-1];
    d_msb_s  = diff_d[BITS_PER_CYCLE-1];
    ovf_s    = (a_msb_s ^ b_msb_s) & (a_msb_s ^ d_msb_s);

    if (signed_q) begin
      lt_d = d_msb_s ^ ovf_s;
    end else begin
      lt_d = borrow_d;
    end

`ifdef SLT_EQ_FLAG_EN
    nz_d = nz_q | (|diff_d);
`endif
  end

  // Control FSM with operand shift registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      signed_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lt_q     <= 1'b0;
`ifdef SLT_EQ_FLAG_EN
      nz_q     <= 1'b0;
      eq_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            signed_q <= is_signed_i;
            borrow_q <= 1'b0;
            count_q  <= '0;
`ifdef SLT_EQ_FLAG_EN
            nz_q     <= 1'b0;
`endif
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            state_q  <= S_IDLE;
          end
        end

        S_RUN: begin
          a_q      <= a_q >> BITS_PER_CYCLE;
          b_q      <= b_q >> BITS_PER_CYCLE;
          borrow_q <= borrow_d;
          count_q  <= count_d;
`ifdef SLT_EQ_FLAG_EN
          nz_q     <= nz_d;
`endif
          if (last_d) begin
            lt_q    <= lt_d;
`ifdef SLT_EQ_FLAG_EN
            eq_q    <= ~nz_d;
`endif
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign lt_o   = lt_q;
`ifdef SLT_EQ_FLAG_EN
  assign eq_o   = eq_q;
`endif

endmodule

// File: tb/tb_slt_serial_compare.sv
module tb_slt_serial_compare;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic         lt;
    logic         eq;
  } vec_t;

  typedef struct packed {
    logic lt;
    logic eq;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   sel;
  logic [2:0]   st;
  logic [2:0]   busy;
  logic [2:0]   done;
  logic [2:0]   lt;
  logic [2:0]   eq;

  int   n_chk    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   lat_tab [3] = '{33, 9, 2};
  exp_t exp_q [$];
  exp_t mon_e;
  vec_t vecs [12];

  always #5 clk = ~clk;

  assign st[0] = start && (sel == 2'd0);
  assign st[1] = start && (sel == 2'd1);
  assign st[2] = start && (sel == 2'd2);

  slt_serial_compare #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(st[0]), .is_signed_i(sgn), .a_i(a), .b_i(b),
    .busy_o(busy[0]), .done_o(done[0]), .lt_o(lt[0])
`ifdef SLT_EQ_FLAG_EN
    , .eq_o(eq[0])
`endif
  );

  slt_serial_compare #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(st[1]), .is_signed_i(sgn), .a_i(a), .b_i(b),
    .busy_o(busy[1]), .done_o(done[1]), .lt_o(lt[1])
`ifdef SLT_EQ_FLAG_EN
    , .eq_o(eq[1])
`endif
  );

  slt_serial_compare #(.WIDTH(W), .BITS_PER_CYCLE(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start_i(st[2]), .is_signed_i(sgn), .a_i(a), .b_i(b),
    .busy_o(busy[2]), .done_o(done[2]), .lt_o(lt[2])
`ifdef SLT_EQ_FLAG_EN
    , .eq_o(eq[2])
`endif
  );

`ifndef SLT_EQ_FLAG_EN
  assign eq = 3'b000;
`endif

  // Scoreboard monitor: every done pulse of the selected instance pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done[sel]) begin
      done_cnt++;
      n_chk++;
      if (busy[sel] !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_with_done: busy=%b required 0 (sel=%0d)", busy[sel], sel);
      end
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: done=1 with no pending request (sel=%0d)", sel);
      end else begin
        mon_e = exp_q.pop_front();
        if (lt[sel] !== mon_e.lt) begin
          n_fail++;
          $display("FAIL lt_result: got %b required %b (sel=%0d)", lt[sel], mon_e.lt, sel);
        end
`ifdef SLT_EQ_FLAG_EN
        n_chk++;
        if (eq[sel] !== mon_e.eq) begin
          n_fail++;
          $display("FAIL eq_result: got %b required %b (sel=%0d)", eq[sel], mon_e.eq, sel);
        end
`endif
      end
    end
  end

  // Issue one operation; caller is positioned just after a falling edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic elt, input logic eeq);
    exp_t x;
    int   cyc;
    logic ok;
    a     = ta;
    b     = tb_v;
    sgn   = ts;
    start = 1'b1;
    x.lt  = elt;
    x.eq  = eeq;
    exp_q.push_back(x);
    cyc = 0;
    ok  = 1'b0;
    while (!ok && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        // Scramble the inputs; the captured operands must be unaffected.
        a   = $urandom;
        b   = $urandom;
        sgn = 1'($urandom_range(0, 1));
        n_chk++;
        if (busy[sel] !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_after_accept: got %b required 1 (sel=%0d)", busy[sel], sel);
        end
      end
      if (done[sel] === 1'b1) ok = 1'b1;
    end
    n_chk++;
    if (!ok || cyc != lat_tab[sel]) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles (done seen=%b) required %0d (sel=%0d)",
               cyc, ok, lat_tab[sel], sel);
    end
    if (!ok) exp_q.delete();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    logic         rlt;
    int           k;
    int           d0;

    vecs[0]  = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, s: 1'b1, lt: 1'b1, eq: 1'b0};
    vecs[1]  = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, s: 1'b0, lt: 1'b0, eq: 1'b0};
    vecs[2]  = '{a: 32'h8000_0000, b: 32'h7FFF_FFFF, s: 1'b1, lt: 1'b1, eq: 1'b0};
    vecs[3]  = '{a: 32'h7FFF_FFFF, b: 32'h8000_0000, s: 1'b1, lt: 1'b0, eq: 1'b0};
    vecs[4]  = '{a: 32'h1234_5678, b: 32'h1234_5678, s: 1'b1, lt: 1'b0, eq: 1'b1};
    vecs[5]  = '{a: 32'h1234_5678, b: 32'h1234_5678, s: 1'b0, lt: 1'b0, eq: 1'b1};
    vecs[6]  = '{a: 32'h0000_0005, b: 32'h0000_0006, s: 1'b0, lt: 1'b1, eq: 1'b0};
    vecs[7]  = '{a: 32'h0000_0005, b: 32'h0000_0006, s: 1'b1, lt: 1'b1, eq: 1'b0};
    vecs[8]  = '{a: 32'h0000_0000, b: 32'hFFFF_FFFF, s: 1'b0, lt: 1'b1, eq: 1'b0};
    vecs[9]  = '{a: 32'h0000_0000, b: 32'hFFFF_FFFF, s: 1'b1, lt: 1'b0, eq: 1'b0};
    vecs[10] = '{a: 32'h8000_0000, b: 32'h0000_0000, s: 1'b1, lt: 1'b1, eq: 1'b0};
    vecs[11] = '{a: 32'h8000_0000, b: 32'h0000_0000, s: 1'b0, lt: 1'b0, eq: 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    sel   = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 3'b000 || done !== 3'b000 || lt !== 3'b000 || eq !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b lt=%b eq=%b required all 000",
               busy, done, lt, eq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Directed table on the 1-bit-per-cycle instance; consecutive ops run back-to-back.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].lt, vecs[i].eq);
    end

    // Reset in the middle of an operation, with lt previously 1.
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    a     = 32'h0000_0003;
    b     = 32'h0000_0002;
    sgn   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || lt[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_op: busy=%b done=%b lt=%b required 0 0 0",
               busy[0], done[0], lt[0]);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    run_op(32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b1, 1'b0);

    // start held high through RUN while the operands change.
    d0    = done_cnt;
    a     = 32'h0000_0005;
    b     = 32'h0000_0006;
    sgn   = 1'b0;
    start = 1'b1;
    exp_q.push_back('{lt: 1'b1, eq: 1'b0});
    @(posedge clk);
    #1;
    repeat (20) begin
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    n_chk++;
    if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL held_start_done_count: got %0d dones (%0d pending) required 1 (0 pending)",
               done_cnt - d0, exp_q.size());
    end
    exp_q.delete();
    @(negedge clk);
    #1;

    // Random sweep across the three slice widths against a behavioural model.
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      @(negedge clk);
      #1;
      for (int n = 0; n < 1000; n++) begin
        k  = $urandom_range(0, 4);
        ra = $urandom;
        case (k)
          0:       rb = ra;
          1:       rb = ra ^ 32'h8000_0000;
          2:       rb = ra + 32'd1;
          default: rb = $urandom;
        endcase
        rs  = 1'($urandom_range(0, 1));
        rlt = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
        run_op(ra, rb, rs, rlt, (ra == rb));
        if ($urandom_range(0, 7) == 0) begin
          repeat (2) @(negedge clk);
          #1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
